// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display slice.
//   GlyphAl   : hex glyph table, active-low gfedcba, indexed by nibble value
//   SegBlank  : all-segments-off pattern in active-high form
//   seg_pol() : maps an active-high segment pattern onto the output polarity
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Index 0 sits in the least significant slot, so GlyphAl[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] GlyphAl = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam seg_t SegBlank = 7'h00;

  function automatic seg_t seg_pol(input seg_t seg_hi, input bit active_low);
    return active_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-glyph decoder.
//   nibble_i : 4-bit hex value
//   glyph_o  : gfedcba pattern, active-high (1 = segment lit)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       glyph_o
);

  assign glyph_o = ~GlyphAl[nibble_i];

endmodule

// File: rtl/seg7_display.sv
// Multi-digit hex seven-segment display driver with leading-zero blanking, per-digit blink,
// and either static per-digit segment buses or a time-multiplexed scan.
//   clk        : sole clock
//   reset_in   : synchronous active-low reset
//   value      : hex nibbles, digit 0 in bits [3:0]
//   load       : single-cycle strobe capturing value
//   lz_en      : leading-zero blanking enable (live)
//   blink_mask : per-digit blink enable (live)
//   seg_static : per-digit segments gfedcba, digit n in bits [7n+6:7n] (static mode)
//   seg_mux    : scanned segments gfedcba (mux mode)
//   dig_sel    : one-hot scanned digit enable (mux mode)
module seg7_display
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          MUX_MODE   = 1'b0,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 12500000
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   seg_static,
  output logic [6:0]            seg_mux,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ScanW  = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IdxW-1:0]   IdxMax   = IdxW'(DIGITS - 1);
  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  localparam seg_t              SegOff = seg_pol(SegBlank, ACTIVE_LOW);
  localparam logic [DIGITS-1:0] DigOff = {DIGITS{ACTIVE_LOW}};

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic                pending_q, pending_d;
  logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]     dig_idx_q, dig_idx_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  logic [7*DIGITS-1:0] seg_static_q, seg_static_d;
  seg_t                seg_mux_q, seg_mux_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;

  logic                frame_end;
  logic [DIGITS-1:0]   blank_vec;
  logic                zero_run;

  // Last slot of the last digit: the only point where the displayed value may change in mux mode.
  assign frame_end = MUX_MODE && (scan_cnt_q == ScanMax) && (dig_idx_q == IdxMax);

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d = value;
    end
    if (!MUX_MODE) begin
      if (load) begin
        active_d = value;
      end
    end else if (frame_end) begin
      // shadow_d already holds a coincident load, so it wins over an older pending value.
      if (load || pending_q) begin
        active_d = shadow_d;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == ScanMax) begin
      scan_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == IdxMax) ? '0 : dig_idx_q + 1'b1;
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BlinkMax) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Walk from the top digit down; zero_run stays set while every digit so far is zero.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run     = zero_run && (active_q[4*i +: 4] == 4'h0);
      blank_vec[i] = (lz_en && zero_run && (i != 0)) || (blink_phase_q && blink_mask[i]);
    end
  end

  if (!MUX_MODE) begin : g_static
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      seg_t glyph;
      seg7_decode u_decode (
        .nibble_i (active_q[4*i +: 4]),
        .glyph_o  (glyph)
      );
      assign seg_static_d[7*i +: 7] = blank_vec[i] ? SegOff : seg_pol(glyph, ACTIVE_LOW);
    end
    assign seg_mux_d = SegOff;
    assign dig_sel_d = DigOff;
  end else begin : g_mux
    seg_t              glyph;
    logic [DIGITS-1:0] sel_onehot;
    seg7_decode u_decode (
      .nibble_i (active_q[{dig_idx_q, 2'b00} +: 4]),
      .glyph_o  (glyph)
    );
    assign sel_onehot   = DIGITS'(1) << dig_idx_q;
    assign seg_static_d = {DIGITS{SegOff}};
    assign seg_mux_d    = blank_vec[dig_idx_q] ? SegOff : seg_pol(glyph, ACTIVE_LOW);
    // First clock of each slot keeps all digits dark so the previous glyph cannot ghost.
    assign dig_sel_d    = (scan_cnt_q == '0) ? DigOff
                        : (ACTIVE_LOW ? ~sel_onehot : sel_onehot);
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      scan_cnt_q    <= '0;
      dig_idx_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_static_q  <= {DIGITS{SegOff}};
      seg_mux_q     <= SegOff;
      dig_sel_q     <= DigOff;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      scan_cnt_q    <= scan_cnt_d;
      dig_idx_q     <= dig_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_static_q  <= seg_static_d;
      seg_mux_q     <= seg_mux_d;
      dig_sel_q     <= dig_sel_d;
    end
  end

  assign seg_static = seg_static_q;
  assign seg_mux    = seg_mux_q;
  assign dig_sel    = dig_sel_q;

endmodule

// File: tb/tb_seg7_display.sv
module tb_seg7_display;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [15:0] value;
  logic        load;
  logic        lz_en;
  logic [3:0]  blink_mask;

  logic [27:0] seg_static_s, seg_static_m;
  logic [6:0]  seg_mux_s, seg_mux_m;
  logic [3:0]  dig_sel_s, dig_sel_m;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_display #(
    .DIGITS(4), .ACTIVE_LOW(1), .MUX_MODE(0), .SCAN_DIV(4), .BLINK_DIV(16)
  ) u_dut_static (
    .clk        (clk),
    .reset_in   (reset_in),
    .value      (value),
    .load       (load),
    .lz_en      (lz_en),
    .blink_mask (blink_mask),
    .seg_static (seg_static_s),
    .seg_mux    (seg_mux_s),
    .dig_sel    (dig_sel_s)
  );

  seg7_display #(
    .DIGITS(4), .ACTIVE_LOW(1), .MUX_MODE(1), .SCAN_DIV(4), .BLINK_DIV(16)
  ) u_dut_mux (
    .clk        (clk),
    .reset_in   (reset_in),
    .value      (value),
    .load       (load),
    .lz_en      (lz_en),
    .blink_mask (blink_mask),
    .seg_static (seg_static_m),
    .seg_mux    (seg_mux_m),
    .dig_sel    (dig_sel_m)
  );

  // Active-low hex glyphs, indexed by nibble.
  logic [6:0] glyph_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0] scan_ref [17] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // t = clocks since reset release; blink phase is simply which 16-clock window t falls in.
  function automatic bit digit_dark(input logic [15:0] act, input int i, input bit lz,
                                    input logic [3:0] mask, input int t);
    bit lead;
    bit blink;
    lead  = lz && (i > 0) && ((act >> (4 * i)) == 16'h0);
    blink = mask[i] && (((t / 16) % 2) == 1);
    return lead || blink;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [15:0] act, input int i, input bit lz,
                                           input logic [3:0] mask, input int t);
    logic [3:0] nib;
    nib = act[4*i +: 4];
    return digit_dark(act, i, lz, mask, t) ? 7'h7F : glyph_ref[nib];
  endfunction

  // Reference model: outputs after an edge reflect the model state just before that edge.
  logic [15:0] m_act_s = '0, m_act_m = '0, m_shadow = '0;
  bit          m_pend = 1'b0;
  int          m_t = 0;

  always begin
    logic [27:0] e_stat_s, e_stat_m;
    logic [6:0]  e_mux_s, e_mux_m;
    logic [3:0]  e_sel_s, e_sel_m;
    int          p;
    int          d;
    @(posedge clk);
    e_stat_m = '1;
    e_mux_s  = 7'h7F;
    e_sel_s  = 4'hF;
    if (!reset_in) begin
      e_stat_s = '1;
      e_mux_m  = 7'h7F;
      e_sel_m  = 4'hF;
      m_act_s  = '0;
      m_act_m  = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      m_t      = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        e_stat_s[7*i +: 7] = digit_seg(m_act_s, i, lz_en, blink_mask, m_t);
      end
      p = m_t % 16;
      d = p / 4;
      e_sel_m = ((p % 4) == 0) ? 4'hF : ~(4'b0001 << d);
      e_mux_m = digit_seg(m_act_m, d, lz_en, blink_mask, m_t);
      if (load) begin
        m_act_s  = value;
        m_shadow = value;
      end
      if (p == 15) begin
        if (load || m_pend) m_act_m = m_shadow;
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      m_t++;
    end
    #1;
    check("model_static_seg", 32'(seg_static_s), 32'(e_stat_s));
    check("model_static_mux", 32'(seg_mux_s), 32'(e_mux_s));
    check("model_static_sel", 32'(dig_sel_s), 32'(e_sel_s));
    check("model_mux_static", 32'(seg_static_m), 32'(e_stat_m));
    check("model_mux_seg", 32'(seg_mux_m), 32'(e_mux_m));
    check("model_mux_sel", 32'(dig_sel_m), 32'(e_sel_m));
  end

  initial begin
    int dark;
    int dark_early;
    int upper_bad;
    reset_in   = 1'b0;
    load       = 1'b0;
    value      = '0;
    lz_en      = 1'b0;
    blink_mask = '0;
    repeat (3) tick();
    check("reset_static", 32'(seg_static_s), 32'hFFFFFFF);
    check("reset_mux_seg", 32'(seg_mux_m), 32'h7F);
    check("reset_mux_sel", 32'(dig_sel_m), 32'hF);

    // Static decode and two-edge latency
    reset_in = 1'b1;
    value = 16'h12AF; load = 1'b1;
    tick(); load = 1'b0;
    check("load_latency", 32'(seg_static_s), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    tick();
    check("hex_12af", 32'(seg_static_s), 32'({7'h79, 7'h24, 7'h08, 7'h0E}));

    // Leading-zero blanking
    lz_en = 1'b1;
    value = 16'h0005; load = 1'b1; tick(); load = 1'b0; tick();
    check("lz_0005", 32'(seg_static_s), 32'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
    value = 16'h0000; load = 1'b1; tick(); load = 1'b0; tick();
    check("lz_0000", 32'(seg_static_s), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    value = 16'h0300; load = 1'b1; tick(); load = 1'b0; tick();
    check("lz_0300", 32'(seg_static_s), 32'({7'h7F, 7'h30, 7'h40, 7'h40}));

    // Scan order, deferred commit, last-write-wins, boundary load
    lz_en = 1'b0; reset_in = 1'b0; tick(); reset_in = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      load = 1'b0;
      if (k == 2)  begin value = 16'h1111; load = 1'b1; end
      if (k == 6)  begin value = 16'h2222; load = 1'b1; end
      if (k == 32) begin value = 16'h3456; load = 1'b1; end
      tick();
      if (k <= 17) check("scan_sel", 32'(dig_sel_m), 32'(scan_ref[k-1]));
      if (k == 5)  check("mux_static_blank", 32'(seg_static_m), 32'hFFFFFFF);
      if (k == 5)  check("static_sel_off", 32'(dig_sel_s), 32'hF);
      if (k == 10) check("pending_old", 32'(seg_mux_m), 32'h40);
      if (k == 16) check("pre_boundary", 32'(seg_mux_m), 32'h40);
      if (k == 17) check("commit_last", 32'(seg_mux_m), 32'h24);
      if (k == 22) check("commit_d1", 32'(seg_mux_m), 32'h24);
      if (k == 33) check("boundary_load_seg", 32'(seg_mux_m), 32'h02);
      if (k == 34) check("boundary_load_sel", 32'(dig_sel_m), 32'hE);
      if (k == 38) check("digit1_seg", 32'(seg_mux_m), 32'h12);
      if (k == 38) check("digit1_sel", 32'(dig_sel_m), 32'hD);
    end
    load = 1'b0;

    // Blink: digit 0 dark for 16 clocks, lit for 16
    reset_in = 1'b0; tick(); reset_in = 1'b1;
    blink_mask = 4'b0001; value = 16'h8888; load = 1'b1;
    dark = 0; dark_early = 0; upper_bad = 0;
    for (int k = 1; k <= 48; k++) begin
      tick(); load = 1'b0;
      if (k >= 2 && k <= 16 && seg_static_s[6:0] == 7'h7F) dark_early++;
      if (k >= 17 && k <= 48 && seg_static_s[6:0] == 7'h7F) dark++;
      if (k >= 2 && seg_static_s[27:7] != 21'h0) upper_bad++;
      if (k == 16) check("blink_lit16", 32'(seg_static_s[6:0]), 32'h00);
      if (k == 17) check("blink_dark17", 32'(seg_static_s[6:0]), 32'h7F);
      if (k == 32) check("blink_dark32", 32'(seg_static_s[6:0]), 32'h7F);
      if (k == 33) check("blink_lit33", 32'(seg_static_s[6:0]), 32'h00);
    end
    check("blink_dark_count", 32'(dark), 32'd16);
    check("blink_early_dark", 32'(dark_early), 32'd0);
    check("blink_others_steady", 32'(upper_bad), 32'd0);
    blink_mask = '0;

    // Reset mid-scan with coincident load
    reset_in = 1'b0; tick(); reset_in = 1'b1;
    value = 16'h7777; load = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick(); load = 1'b0;
      if (k == 22) check("pre_reset_seg", 32'(seg_mux_m), 32'h78);
    end
    reset_in = 1'b0; value = 16'hABCD; load = 1'b1;
    tick();
    check("midreset_static", 32'(seg_static_s), 32'hFFFFFFF);
    check("midreset_mux_seg", 32'(seg_mux_m), 32'h7F);
    check("midreset_mux_sel", 32'(dig_sel_m), 32'hF);
    reset_in = 1'b1; load = 1'b0;
    tick();
    check("post_reset_static", 32'(seg_static_s), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    check("post_reset_sel0", 32'(dig_sel_m), 32'hF);
    check("post_reset_seg0", 32'(seg_mux_m), 32'h40);
    tick();
    check("post_reset_sel1", 32'(dig_sel_m), 32'hE);
    check("post_reset_seg1", 32'(seg_mux_m), 32'h40);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset_in = ($urandom_range(0, 249) != 0);
      load     = ($urandom_range(0, 3) == 0);
      value    = 16'($urandom);
      if ($urandom_range(0, 31) == 0) lz_en = 1'($urandom);
      if ($urandom_range(0, 47) == 0) blink_mask = 4'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_display.md
SEG7_DISPLAY -- requirements
Module: seg7_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of hex digits (1..8).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, segment and digit-select polarity (1 = lit when 0).
REQ-003 SHALL have parameter MUX_MODE, default 0, output mode (0 = static per-digit buses, 1 = time-multiplexed scan).
REQ-004 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot in mux mode (>=2).
REQ-005 SHALL have parameter BLINK_DIV, default 12500000, clocks per blink half-period (>=1).
REQ-006 SHALL have port clk, input, 1, sole clock; one clock domain; reset is synchronous and active-low.
REQ-007 SHALL have port reset_in, input, 1, synchronous active-low reset.
REQ-008 SHALL have port value, input, 4*DIGITS, hex nibbles; digit 0 = bits [3:0].
REQ-009 SHALL have port load, input, 1, single-cycle strobe that captures value.
REQ-010 SHALL have port lz_en, input, 1, leading-zero blanking enable.
REQ-011 SHALL have port blink_mask, input, DIGITS, per-digit blink enable.
REQ-012 SHALL have port seg_static, output, 7*DIGITS, per-digit segments gfedcba; digit n = bits [7n+6:7n].
REQ-013 SHALL have port seg_mux, output, 7, scanned segments gfedcba.
REQ-014 SHALL have port dig_sel, output, DIGITS, one-hot scanned digit enable.

Function
REQ-015 SHALL decode each nibble to standard hex glyphs 0-9, A, b, C, d, E, F; active-low codes 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10,0x08,0x03,0x46,0x21,0x06,0x0E; active-high is the bitwise inverse; blank is all segments off.
REQ-016 SHALL hold two registers: shadow (written on load) and active (drives display).
REQ-017 SHALL, when MUX_MODE=0, copy value into shadow and active at the load edge, with registered seg_static showing the new glyphs at the next edge (latency 2 edges from load sampled).
REQ-018 SHALL, when MUX_MODE=1, set a pending flag on load and commit shadow into active only at a frame boundary (scan terminal count with digit index = DIGITS-1).
REQ-019 SHALL resolve a load during pending as last-write-wins in shadow.
REQ-020 SHALL, when load coincides with a frame-boundary edge, commit the incoming value straight into active and clear pending.
REQ-021 SHALL run the scan counter 0..SCAN_DIV-1 and, at terminal count, advance the digit index with wrap from DIGITS-1 to 0.
REQ-022 SHALL drive dig_sel all inactive for the first clock of every digit slot (anti-ghost), then one-hot for the slot's index.
REQ-023 SHALL, with lz_en=1, blank every digit above the most significant non-zero digit of active; digit 0 is never blanked by this rule.
REQ-024 SHALL toggle a blink phase every BLINK_DIV clocks and blank digits with blink_mask set while the phase is 1.
REQ-025 SHALL combine blanking as OR of leading-zero and blink conditions, sampling blink_mask and lz_en live (not double-buffered).
REQ-026 SHALL register all outputs; when MUX_MODE=0, seg_mux is blank and dig_sel inactive; when MUX_MODE=1, seg_static is all blank.

Reset
REQ-027 SHALL, while reset_in=0 at an edge, clear shadow, active, pending, scan counter, digit index, and blink phase to 0.
REQ-028 SHALL reset seg_static and seg_mux to blank (0x7F per digit when ACTIVE_LOW=1) and dig_sel to all inactive.
REQ-029 SHALL discard a load sampled in the same cycle as reset, and shall abandon a scan aborted by mid-frame reset, restarting at digit 0 slot start.

Structure
REQ-030 SHALL place the glyph table, blank constant, and polarity helper in shared package seg7_pkg.
REQ-031 SHALL use one combinational sub-module seg7_decode (nibble in, 7-bit active-high glyph out), instantiated per digit (static) or once (mux).

Verification
REQ-032 SHALL check that, with MUX_MODE=0 and DIGITS=4, load with value=0x12AF gives seg_static digits 3..0 = 0x79,0x24,0x08,0x0E two edges later.
REQ-033 SHALL check that, with lz_en=1 and value=0x0005, digits 3..1 are 0x7F and digit 0 is 0x12; value=0x0000 shows only digit 0 = 0x40.
REQ-034 SHALL check that, with MUX_MODE=1 and SCAN_DIV=4, dig_sel follows 1111,1110×3,1111,1101×3,... wrapping after digit 3, with seg_mux matching each slot.
REQ-035 SHALL check that, in MUX_MODE=1, load 0x1111 then 0x2222 mid-frame shows old active until the frame boundary and then 0x2222 only; a load on the boundary edge commits immediately.
REQ-036 SHALL check that, with BLINK_DIV=16 and blink_mask=0001, digit 0 is blank for 16 clocks and lit for 16 clocks repeatedly while others are steady.
REQ-037 SHALL check that reset_in=0 asserted mid-scan with a simultaneous load gives all blank and dig_sel=1111 next edge, active=0, and the scan restarting at digit 0 after release.
